// File: rtl/tram_console_if.sv
// Byte-stream input and tram system-port write bus for tram_console.
interface tram_console_if #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned BYTE_CNT = 4,
  parameter int unsigned ADDRW    = 11
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          colr_fg;
  logic [3:0]          colr_bg;
  logic [BYTE_CNT-1:0] tram_we;
  logic [ADDRW-1:0]    tram_addr;
  logic [WORD-1:0]     tram_din;

  modport master (
    output in_data, in_valid, colr_fg, colr_bg,
    input  in_ready, tram_we, tram_addr, tram_din
  );

  modport slave (
    input  in_data, in_valid, colr_fg, colr_bg,
    output in_ready, tram_we, tram_addr, tram_din
  );
endinterface

// File: rtl/tram_console.sv
// Text console: turns a byte stream into tram writes with cursor, line wrap and circular scroll.
// Define TRAM_CONSOLE_TAB_EN to build the tab-expansion state for byte 0x09.
module tram_console #(
  parameter int unsigned WORD      = 32,
  parameter int unsigned BYTE_CNT  = 4,
  parameter int unsigned ADDRW     = 11,
  parameter int unsigned TRAM_HRES = 84,
  parameter int unsigned TRAM_VRES = 24,
  parameter int unsigned TAB_W     = 4
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  tram_console_if.slave    bus,
  output logic [ADDRW-1:0] scroll_offs,
  output logic [6:0]       cur_col,
  output logic [4:0]       cur_row,
  output logic             busy
);

  localparam int unsigned      DEPTH    = TRAM_HRES * TRAM_VRES;
  localparam logic [6:0]       ColLast  = 7'(TRAM_HRES - 1);
  localparam logic [4:0]       RowLast  = 5'(TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] Hres     = ADDRW'(TRAM_HRES);
  localparam logic [ADDRW-1:0] HresLast = ADDRW'(TRAM_HRES - 1);
  localparam logic [ADDRW-1:0] DepLast  = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW:0]   DepthW   = (ADDRW + 1)'(DEPTH);
  localparam logic [7:0]       Space    = 8'h20;

  if (((TAB_W & (TAB_W - 1)) != 0) || ((TRAM_HRES % TAB_W) != 0)) begin : g_bad_tab
    $error("TAB_W must be a power of two that divides TRAM_HRES");
  end

  typedef enum logic [1:0] {
    StIdle,
    StClrLine,
`ifdef TRAM_CONSOLE_TAB_EN
    StTab,
`endif
    StClrScr
  } state_e;

  state_e              state_q, state_d;
  logic [6:0]          col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [ADDRW-1:0]    row_base_q, row_base_d;
  logic [ADDRW-1:0]    scroll_q, scroll_d;
  logic [ADDRW-1:0]    cnt_q, cnt_d;
  logic [3:0]          fg_q, fg_d, bg_q, bg_d;
  logic [BYTE_CNT-1:0] we_q, we_d;
  logic [ADDRW-1:0]    addr_q, addr_d;
  logic [WORD-1:0]     din_q, din_d;
  logic                do_nl;
  logic [ADDRW-1:0]    cur_addr;

  // Both operands are below DEPTH, so a single conditional subtract wraps the sum.
  function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] a,
                                                input logic [ADDRW-1:0] b);
    logic [ADDRW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DepthW) s = s - DepthW;
    return s[ADDRW-1:0];
  endfunction

  function automatic logic [WORD-1:0] mk_word(input logic [3:0] fg, input logic [3:0] bg,
                                              input logic [7:0] ch);
    return {fg, bg, {(WORD - 16){1'b0}}, ch};
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    scroll_d   = scroll_q;
    cnt_d      = cnt_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    we_d       = '0;
    addr_d     = addr_q;
    din_d      = din_q;
    do_nl      = 1'b0;
    cur_addr   = wrap_add(scroll_q, row_base_q + ADDRW'(col_q));

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          fg_d = bus.colr_fg;
          bg_d = bus.colr_bg;
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            we_d   = '1;
            addr_d = cur_addr;
            din_d  = mk_word(bus.colr_fg, bus.colr_bg, bus.in_data);
            if (col_q == ColLast) begin
              col_d = '0;
              do_nl = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (bus.in_data)
              8'h0A: begin
                col_d = '0;
                do_nl = 1'b1;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != '0) begin
                  col_d  = col_q - 7'd1;
                  we_d   = '1;
                  addr_d = wrap_add(scroll_q, row_base_q + ADDRW'(col_q - 7'd1));
                  din_d  = mk_word(bus.colr_fg, bus.colr_bg, Space);
                end
              end
              8'h0C: begin
                state_d    = StClrScr;
                scroll_d   = '0;
                col_d      = '0;
                row_d      = '0;
                row_base_d = '0;
                cnt_d      = '0;
              end
`ifdef TRAM_CONSOLE_TAB_EN
              8'h09: state_d = StTab;
`endif
              default: ;
            endcase
          end
        end
      end
      StClrLine: begin
        we_d   = '1;
        addr_d = wrap_add(scroll_q, row_base_q + cnt_q);
        din_d  = mk_word(fg_q, bg_q, Space);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == HresLast) state_d = StIdle;
      end
      StClrScr: begin
        we_d   = '1;
        addr_d = cnt_q;
        din_d  = mk_word(fg_q, bg_q, Space);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == DepLast) state_d = StIdle;
      end
`ifdef TRAM_CONSOLE_TAB_EN
      StTab: begin
        we_d   = '1;
        addr_d = cur_addr;
        din_d  = mk_word(fg_q, bg_q, Space);
        if (col_q == ColLast) begin
          col_d   = '0;
          do_nl   = 1'b1;
          state_d = StIdle;
        end else begin
          col_d = col_q + 7'd1;
          if ((col_d & 7'(TAB_W - 1)) == 7'd0) state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Scrolling only moves the start offset; the newly exposed bottom row is then cleared.
    if (do_nl) begin
      if (row_q != RowLast) begin
        row_d      = row_q + 5'd1;
        row_base_d = row_base_q + Hres;
      end else begin
        scroll_d = wrap_add(scroll_q, Hres);
        cnt_d    = '0;
        state_d  = StClrLine;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      scroll_q   <= '0;
      cnt_q      <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      we_q       <= '0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      scroll_q   <= scroll_d;
      cnt_q      <= cnt_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.tram_we   = we_q;
  assign bus.tram_addr = addr_q;
  assign bus.tram_din  = din_q;
  assign scroll_offs   = scroll_q;
  assign cur_col       = col_q;
  assign cur_row       = row_q;
  assign busy          = (state_q != StIdle);

endmodule
